// File: rtl/lenet_pkg.sv
// lenet_pkg: constants, pooling FSM states and feature-map BRAM addressing
// shared by the LeNet feature-map writer and reader stages.
package lenet_pkg;

    localparam int FM_W        = 16;
    localparam int LANES       = 56;
    localparam int VALID_LANES = 50;
    localparam int MAP_DIM     = 10;
    localparam int POOL_DIM    = 5;

    typedef enum logic [2:0] {IDLE, READ, WAIT, POOL, EMIT, DONE} pool_state_t;

    // Even maps sit in the low half of the BRAM, odd maps 16 words up; two words per map.
    function automatic logic [6:0] fm1_base_addr(input logic [3:0] m);
        return {2'b00, m[0], m[3:1], 1'b0};
    endfunction

endpackage

// File: rtl/pool2x2_row.sv
// pool2x2_row: 2x2 stride-2 signed max pooling of two adjacent 10-value rows,
// with optional clamping of negative results to zero.
module pool2x2_row
    import lenet_pkg::*;
#(
    parameter bit RELU = 1
) (
    input  logic [MAP_DIM*FM_W-1:0]  top,
    input  logic [MAP_DIM*FM_W-1:0]  bot,
    output logic [POOL_DIM*FM_W-1:0] q
);

    for (genvar c = 0; c < POOL_DIM; c++) begin : g_col
        logic signed [FM_W-1:0] a, b, d, e, m0, m1, mx;
        assign a  = top[(2*c)*FM_W +: FM_W];
        assign b  = top[(2*c+1)*FM_W +: FM_W];
        assign d  = bot[(2*c)*FM_W +: FM_W];
        assign e  = bot[(2*c+1)*FM_W +: FM_W];
        assign m0 = (a > b) ? a : b;
        assign m1 = (d > e) ? d : e;
        assign mx = (m0 > m1) ? m0 : m1;
        assign q[c*FM_W +: FM_W] = (RELU && mx[FM_W-1]) ? '0 : mx;
    end

endmodule

// File: rtl/pool_2_reader.sv
// pool_2_reader: reads conv-2 maps back from fm_bram_1, max-pools each to 5x5
// and streams one pooled row per valid/ready beat.
module pool_2_reader
    import lenet_pkg::*;
#(
    parameter int RD_LAT   = 2,
    parameter bit RELU     = 1,
    parameter int NUM_MAPS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pool_2_en,
    output logic         fm_bram_1_ena,
    output logic         fm_bram_1_enb,
    output logic [6:0]   fm_bram_1_addra,
    output logic [6:0]   fm_bram_1_addrb,
    input  logic [895:0] fm_bram_1_douta,
    input  logic [895:0] fm_bram_1_doutb,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [79:0]  out_data,
    output logic [3:0]   out_map,
    output logic [2:0]   out_row,
    output logic         pool_2_finish
);

    localparam int LW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int WORD  = LANES*FM_W;
    localparam int PAD   = (LANES-VALID_LANES)*FM_W;

    pool_state_t state, state_nx;
    logic                                en_q, rise, lat_done, beat, last_row;
    logic [3:0]                          map;
    logic [2:0]                          row;
    logic [LW-1:0]                       lat_cnt;
    logic [2*WORD-1:0]                   map_buf;
    logic [MAP_DIM-1:0][MAP_DIM*FM_W-1:0] in_row;
    logic [POOL_DIM-1:0][POOL_DIM*FM_W-1:0] pooled, res;
    logic                                unused_pad;

    assign rise     = pool_2_en && !en_q;
    assign lat_done = lat_cnt == LW'(RD_LAT-1);
    assign beat     = out_valid && out_ready;
    assign last_row = row == 3'(POOL_DIM-1);

    // Word A carries map rows 0-4, word B rows 5-9; the top six lanes of each are padding.
    for (genvar r = 0; r < MAP_DIM; r++) begin : g_in
        assign in_row[r] = map_buf[(r/POOL_DIM)*WORD + (r%POOL_DIM)*MAP_DIM*FM_W +: MAP_DIM*FM_W];
    end
    assign unused_pad = ^{map_buf[2*WORD-1 -: PAD], map_buf[WORD-1 -: PAD]};

    for (genvar r = 0; r < POOL_DIM; r++) begin : g_pool
        pool2x2_row #(.RELU(RELU)) u_row (
            .top(in_row[2*r]),
            .bot(in_row[2*r+1]),
            .q  (pooled[r])
        );
    end

    always_comb begin
        state_nx = state;
        if (state != IDLE && !pool_2_en) state_nx = IDLE;
        else begin
            case (state)
                IDLE:    state_nx = rise ? READ : IDLE;
                READ:    state_nx = WAIT;
                WAIT:    state_nx = lat_done ? POOL : WAIT;
                POOL:    state_nx = EMIT;
                EMIT:    state_nx = (beat && last_row) ? ((map == 4'(NUM_MAPS-1)) ? DONE : READ) : EMIT;
                DONE:    state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            en_q    <= pool_2_en;
            map     <= '0;
            row     <= '0;
            lat_cnt <= '0;
            map_buf <= '0;
            res     <= '0;
        end else begin
            state   <= state_nx;
            en_q    <= pool_2_en;
            lat_cnt <= (state == WAIT) ? lat_cnt + 1'b1 : '0;
            if (state == IDLE && rise) map <= '0;
            else if (state == EMIT && state_nx == READ) map <= map + 1'b1;
            if (state != EMIT) row <= '0;
            else if (beat) row <= last_row ? '0 : row + 1'b1;
            if (state == WAIT && lat_done) map_buf <= {fm_bram_1_doutb, fm_bram_1_douta};
            if (state == POOL) res <= pooled;
        end
    end

    assign fm_bram_1_ena   = state == READ;
    assign fm_bram_1_enb   = state == READ;
    assign fm_bram_1_addra = fm_bram_1_ena ? fm1_base_addr(map) : '0;
    assign fm_bram_1_addrb = fm_bram_1_enb ? fm1_base_addr(map) + 7'd1 : '0;
    assign out_valid       = state == EMIT;
    assign out_data        = out_valid ? res[row] : '0;
    assign out_map         = out_valid ? map : '0;
    assign out_row         = out_valid ? row : '0;
    assign pool_2_finish   = state == DONE;

endmodule
